player_motion: RTL and testbench
================================

Name: player_motion

Overview:
- Upstream producer of player_h, player_v and level for the collision/scoring stage.
- Consumes that stage's reset_player.
- Moves the player sprite on a 640x480 field from button levels, one step per frame tick, with clamping.
- Runs respawn hold-off after a collision and advances the level when the player crosses the goal column.

Parameters:
H_START 40 — respawn horizontal position (sprite centre)
V_START 240 — respawn vertical position
H_MAX 620 — rightmost allowed player_h
V_MIN 20 — topmost allowed player_v
V_MAX 459 — bottommost allowed player_v
H_GOAL 600 — player_h at/above this completes the level
STEP 4 — pixels moved per move_tick per axis
MAX_LEVEL 9 — final level; completing it ends the game
RESPAWN_TICKS 8 — move_ticks held at start before control resumes

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
move_tick  in  1  one-cycle frame pulse (~60 Hz), movement strobe
btn_up  in  1  synchronized level, move up (decrease v)
btn_down  in  1  synchronized level, move down (increase v)
btn_left  in  1  synchronized level, move left
btn_right  in  1  synchronized level, move right
reset_player  in  1  collision/respawn request from scoring stage
player_h  out  10  sprite centre x
player_v  out  10  sprite centre y
level  out  10  current level, 1-based
level_up  out  1  one-cycle pulse on level increment
game_won  out  1  high after MAX_LEVEL completed
state_dbg  out  2  current FSM state (RESPAWN=0, PLAY=1, ADVANCE=2, WON=3)

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clk is the clock. All outputs are registered.
- Reset values: player_h=H_START, player_v=V_START, level=1, level_up=0, game_won=0, state=RESPAWN, hold counter=RESPAWN_TICKS.
- RESPAWN:
  - h/v forced to start.
  - Counter decrements on each move_tick.
  - reset_player=1 in any cycle reloads the counter.
  - When the counter is 0 and reset_player=0 → PLAY on the next clk.
  - Buttons are ignored.
- PLAY, on move_tick:
  - Each axis updates independently.
  - Up: v = (v < V_MIN+STEP) ? V_MIN : v-STEP.
  - Down: v = (v+STEP > V_MAX) ? V_MAX : v+STEP.
  - Left: clamp at H_START. Right: clamp at H_MAX.
  - Both buttons of one axis pressed → that axis holds.
  - Comparisons use 11-bit intermediates; no 10-bit wrap is permitted.
  - Cycles without move_tick → position holds.
- PLAY, collision: reset_player=1 in any cycle → next cycle h/v=start, counter=RESPAWN_TICKS, state=RESPAWN. This wins over a coincident move_tick; the position does not move that cycle.
- PLAY, goal: when the registered player_h >= H_GOAL and reset_player=0 → ADVANCE. This is checked on the cycle after the move lands.
- ADVANCE (exactly 1 cycle):
  - If level == MAX_LEVEL → WON and game_won=1. Position is held.
  - Otherwise: level+1, level_up=1 for that single cycle, h/v=start, counter reload, → RESPAWN.
  - reset_player is ignored in ADVANCE.
- WON: outputs frozen and game_won=1 until reset. reset_player and buttons are ignored.
- Reset mid-operation (any state, any cycle): immediate return to reset values. A pending level_up is cancelled.
- Level never exceeds MAX_LEVEL and never drops below 1. The downstream score uses (level-1), so level=0 must never appear.

Test Plan:
- Reset, then 8 move_ticks with no buttons → state_dbg 0→1 exactly after the 8th tick; h=40, v=240; level=1.
- In PLAY, btn_up held for 60 ticks from v=240 → v reaches 20 after 55 ticks and stays 20; btn_down held → clamps at 459; no wrap values are seen.
- btn_left+btn_right together with btn_up for 3 ticks → h unchanged at 40, v=228.
- In PLAY at h=200, v=100: reset_player pulsed in the same cycle as move_tick with btn_right → next cycle h=40, v=240, state RESPAWN. reset_player held high for 5 further ticks delays PLAY until 8 ticks after release.
- btn_right held from h=40 → player_h reaches 600 at tick 140. The next cycle is ADVANCE, then level=2, a single-cycle level_up, h=40, v=240, RESPAWN.
- Level 9 forced via repeated runs, then goal reached → game_won=1, level stays 9, no level_up. Buttons and reset_player have no effect; an asynchronous reset mid-run restores level=1, game_won=0.

Source files
------------

// File: rtl/player_motion.sv
// Player sprite motion on a 640x480 field: per-frame stepping with clamping,
// respawn hold-off after collisions and level progression at the goal column.
module player_motion #(
    parameter int unsigned H_START       = 40,
    parameter int unsigned V_START       = 240,
    parameter int unsigned H_MAX         = 620,
    parameter int unsigned V_MIN         = 20,
    parameter int unsigned V_MAX         = 459,
    parameter int unsigned H_GOAL        = 600,
    parameter int unsigned STEP          = 4,
    parameter int unsigned MAX_LEVEL     = 9,
    parameter int unsigned RESPAWN_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       reset_player,
    output logic [9:0] player_h,
    output logic [9:0] player_v,
    output logic [9:0] level,
    output logic       level_up,
    output logic       game_won,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        RESPAWN = 2'd0,
        PLAY    = 2'd1,
        ADVANCE = 2'd2,
        WON     = 2'd3
    } state_t;

    localparam int unsigned CW = $clog2(RESPAWN_TICKS + 1);

    localparam logic [9:0]    H_START10   = 10'(H_START);
    localparam logic [9:0]    V_START10   = 10'(V_START);
    localparam logic [9:0]    H_MAX10     = 10'(H_MAX);
    localparam logic [9:0]    V_MIN10     = 10'(V_MIN);
    localparam logic [9:0]    V_MAX10     = 10'(V_MAX);
    localparam logic [9:0]    STEP10      = 10'(STEP);
    localparam logic [9:0]    MAX_LEVEL10 = 10'(MAX_LEVEL);
    localparam logic [10:0]   H_START11   = 11'(H_START);
    localparam logic [10:0]   H_MAX11     = 11'(H_MAX);
    localparam logic [10:0]   V_MIN11     = 11'(V_MIN);
    localparam logic [10:0]   V_MAX11     = 11'(V_MAX);
    localparam logic [10:0]   H_GOAL11    = 11'(H_GOAL);
    localparam logic [10:0]   STEP11      = 11'(STEP);
    localparam logic [CW-1:0] HOLD_LOAD   = CW'(RESPAWN_TICKS);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [9:0]    h_nx, v_nx, level_nx;
    logic          level_up_nx, game_won_nx;
    logic [10:0]   h_ext, v_ext;
    logic [9:0]    h_mv, v_mv;

    // Candidate position after one step; 11-bit compares keep the clamps wrap-free.
    always_comb begin
        h_ext = {1'b0, player_h};
        v_ext = {1'b0, player_v};
        h_mv  = player_h;
        v_mv  = player_v;
        if (btn_up && !btn_down)
            v_mv = (v_ext < V_MIN11 + STEP11) ? V_MIN10 : player_v - STEP10;
        else if (btn_down && !btn_up)
            v_mv = (v_ext + STEP11 > V_MAX11) ? V_MAX10 : player_v + STEP10;
        if (btn_left && !btn_right)
            h_mv = (h_ext < H_START11 + STEP11) ? H_START10 : player_h - STEP10;
        else if (btn_right && !btn_left)
            h_mv = (h_ext + STEP11 > H_MAX11) ? H_MAX10 : player_h + STEP10;
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        h_nx        = player_h;
        v_nx        = player_v;
        level_nx    = level;
        level_up_nx = 1'b0;
        game_won_nx = game_won;
        unique case (state)
            RESPAWN: begin
                h_nx = H_START10;
                v_nx = V_START10;
                if (reset_player)
                    cnt_nx = HOLD_LOAD;
                else if (cnt == '0)
                    state_nx = PLAY;
                else if (move_tick)
                    cnt_nx = cnt - CW'(1);
            end
            PLAY: begin
                if (reset_player) begin
                    h_nx     = H_START10;
                    v_nx     = V_START10;
                    cnt_nx   = HOLD_LOAD;
                    state_nx = RESPAWN;
                end else if ({1'b0, player_h} >= H_GOAL11) begin
                    state_nx = ADVANCE;
                end else if (move_tick) begin
                    h_nx = h_mv;
                    v_nx = v_mv;
                end
            end
            ADVANCE: begin
                if (level >= MAX_LEVEL10) begin
                    state_nx    = WON;
                    game_won_nx = 1'b1;
                end else begin
                    level_nx    = level + 10'd1;
                    level_up_nx = 1'b1;
                    h_nx        = H_START10;
                    v_nx        = V_START10;
                    cnt_nx      = HOLD_LOAD;
                    state_nx    = RESPAWN;
                end
            end
            WON: begin
                game_won_nx = 1'b1;
            end
            default: state_nx = RESPAWN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RESPAWN;
            cnt      <= HOLD_LOAD;
            player_h <= H_START10;
            player_v <= V_START10;
            level    <= 10'd1;
            level_up <= 1'b0;
            game_won <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            player_h <= h_nx;
            player_v <= v_nx;
            level    <= level_nx;
            level_up <= level_up_nx;
            game_won <= game_won_nx;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_player_motion.sv
// Randomized bench for player_motion, checked cycle by cycle against a
// behavioural model that applies the movement/respawn/level rules arithmetically.
module tb_player_motion;

    logic       clk = 1'b0;
    logic       reset;
    logic       move_tick, btn_up, btn_down, btn_left, btn_right, reset_player;
    logic [9:0] player_h, player_v, level;
    logic       level_up, game_won;
    logic [1:0] state_dbg;

    int total = 0;
    int bad   = 0;

    // Reference model state: mode 0 hold-off, 1 play, 2 advance, 3 won.
    int m_mode, m_hold, m_h, m_v, m_lvl, m_up, m_won;

    player_motion #(
        .H_START(40), .V_START(240), .H_MAX(620), .V_MIN(20), .V_MAX(459),
        .H_GOAL(600), .STEP(4), .MAX_LEVEL(9), .RESPAWN_TICKS(8)
    ) dut (
        .clk(clk), .reset(reset), .move_tick(move_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .reset_player(reset_player),
        .player_h(player_h), .player_v(player_v), .level(level),
        .level_up(level_up), .game_won(game_won), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int x, input int lo, input int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_hold = 8; m_h = 40; m_v = 240; m_lvl = 1; m_up = 0; m_won = 0;
    endtask

    task automatic model_step(input bit tk, input bit u, input bit d,
                              input bit l, input bit r, input bit rp);
        int dx, dy;
        dx = int'(r) - int'(l);
        dy = int'(d) - int'(u);
        m_up = 0;
        if (m_mode == 0) begin
            if (rp) m_hold = 8;
            else if (m_hold == 0) m_mode = 1;
            else if (tk) m_hold = m_hold - 1;
        end else if (m_mode == 1) begin
            if (rp) begin
                m_h = 40; m_v = 240; m_hold = 8; m_mode = 0;
            end else if (m_h >= 600) begin
                m_mode = 2;
            end else if (tk) begin
                m_h = clamp(m_h + 4 * dx, 40, 620);
                m_v = clamp(m_v + 4 * dy, 20, 459);
            end
        end else if (m_mode == 2) begin
            if (m_lvl == 9) begin
                m_mode = 3; m_won = 1;
            end else begin
                m_lvl++; m_up = 1; m_h = 40; m_v = 240; m_hold = 8; m_mode = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("h", int'(player_h), m_h);
        check("v", int'(player_v), m_v);
        check("level", int'(level), m_lvl);
        check("level_up", int'(level_up), m_up);
        check("game_won", int'(game_won), m_won);
        check("state", int'(state_dbg), m_mode);
    endtask

    task automatic step(input bit tk, input bit u, input bit d,
                        input bit l, input bit r, input bit rp);
        move_tick = tk; btn_up = u; btn_down = d;
        btn_left = l; btn_right = r; reset_player = rp;
        @(posedge clk);
        model_step(tk, u, d, l, r, rp);
        #1;
        compare_all();
    endtask

    initial begin
        move_tick = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        reset_player = 0;
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_h", int'(player_h), 40);
        check("rst_v", int'(player_v), 240);
        check("rst_level", int'(level), 1);
        check("rst_state", int'(state_dbg), 0);
        check("rst_won", int'(game_won), 0);
        @(negedge clk);
        reset = 0;

        // Hold-off: 8 ticks leave the counter at zero, the following cycle enters play.
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0);
        check("holdoff_still_respawn", int'(state_dbg), 0);
        step(0, 0, 0, 0, 0, 0);
        check("holdoff_play", int'(state_dbg), 1);

        for (int i = 0; i < 60; i++) step(1, 1, 0, 0, 0, 0);
        check("top_clamp", int'(player_v), 20);
        for (int i = 0; i < 120; i++) step(1, 0, 1, 0, 0, 0);
        check("bottom_clamp", int'(player_v), 459);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 1, 0);
        check("lr_hold_h", int'(player_h), 40);
        check("lr_hold_v", int'(player_v), 447);

        // Collision coincident with a tick: respawn wins, then extended hold-off.
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 1);
        check("coll_h", int'(player_h), 40);
        check("coll_state", int'(state_dbg), 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0, 0);
        check("coll_replay", int'(state_dbg), 1);

        // Random mix with rare collisions.
        for (int i = 0; i < 3000; i++)
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0),
                 bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 7) == 0),
                 bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 511) == 0));

        // Drive right until the final level is cleared.
        for (int i = 0; i < 20000 && m_won == 0; i++)
            step(1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0, 1, 0);
        check("won_reached", int'(game_won), 1);
        check("won_level", int'(level), 9);

        for (int i = 0; i < 200; i++)
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));

        // Asynchronous reset away from the clock edge.
        #2;
        reset = 1;
        model_reset();
        #1;
        check("async_level", int'(level), 1);
        check("async_won", int'(game_won), 0);
        check("async_state", int'(state_dbg), 0);
        check("async_h", int'(player_h), 40);
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 40; i++) step(1, 0, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
